axi4_switch_custom: RTL and testbench

- 2-input to 1-output AXI4-Stream packet switch (arbitrating mux) with per-input request suppression.
- Merges two upstream streams (s0, s1) onto one downstream stream (m0).
- Arbitration happens only at packet boundaries. A granted input keeps the output until its tlast beat handshakes, so packets are never interleaved.
- Sits between two packet producers and one consumer in the streaming datapath.

---
 rtl/axi4_switch_pkg.sv | 6 +
 rtl/axi4_switch_rr_arbiter.sv | 20 ++
 rtl/axi4_switch_custom.sv | 147 ++++++++++++++
 tb/tb_axi4_switch_custom.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_switch_pkg.sv
// Shared types for the 2:1 AXI4-Stream packet switch.
package axi4_switch_pkg;
  localparam int unsigned NUM_IN = 2;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
endpackage

// File: rtl/axi4_switch_rr_arbiter.sv
// Two-input round-robin arbiter: on contention the input not served last wins.
module axi4_switch_rr_arbiter
  import axi4_switch_pkg::*;
(
  input  logic [NUM_IN-1:0] req_i,
  input  logic              last_served_i,
  output logic [NUM_IN-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_served_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/axi4_switch_custom.sv
// 2:1 AXI4-Stream packet switch, arbitrating only at packet boundaries.
// Define AXIS_SWITCH_OUT_REG_EN to register the output through a 2-entry skid buffer.
module axi4_switch_custom
  import axi4_switch_pkg::*;
#(
  parameter int unsigned TDATA_L = 512,
  parameter int unsigned TUSER_L = 81,
  parameter int unsigned TKEEP_L = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         s_req_supress,
  input  logic [TDATA_L-1:0] axi_s0_tdata_i,
  input  logic [TUSER_L-1:0] axi_s0_tuser_i,
  input  logic               axi_s0_tlast_i,
  input  logic [TKEEP_L-1:0] axi_s0_tkeep_i,
  input  logic               axi_s0_tvalid_i,
  output logic               axi_s0_tready_o,
  input  logic [TDATA_L-1:0] axi_s1_tdata_i,
  input  logic [TUSER_L-1:0] axi_s1_tuser_i,
  input  logic               axi_s1_tlast_i,
  input  logic [TKEEP_L-1:0] axi_s1_tkeep_i,
  input  logic               axi_s1_tvalid_i,
  output logic               axi_s1_tready_o,
  output logic [TDATA_L-1:0] axi_m0_tdata_o,
  output logic [TUSER_L-1:0] axi_m0_tuser_o,
  output logic               axi_m0_tlast_o,
  output logic [TKEEP_L-1:0] axi_m0_tkeep_o,
  output logic               axi_m0_tvalid_o,
  input  logic               axi_m0_tready_i
);

  localparam int unsigned PayW = TDATA_L + TUSER_L + TKEEP_L + 1;

  state_t            state_q, state_d;
  logic              last_served_q, last_served_d;
  logic [NUM_IN-1:0] req, grant;
  logic              sel_vld, sel, vld_sel, up_ready, hs;
  logic [PayW-1:0]   pay_sel, pay_out;
  logic              m0_valid;

  assign req = {axi_s1_tvalid_i & ~s_req_supress[1], axi_s0_tvalid_i & ~s_req_supress[0]};

  axi4_switch_rr_arbiter u_arb (
    .req_i         (req),
    .last_served_i (last_served_q),
    .grant_o       (grant)
  );

  // A held lock ignores suppression so an in-flight packet always completes.
  always_comb begin
    sel_vld = 1'b0;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_vld = |grant;
        sel     = grant[1];
      end
      LOCK0: sel_vld = 1'b1;
      LOCK1: begin
        sel_vld = 1'b1;
        sel     = 1'b1;
      end
      default: ;
    endcase
    pay_sel = '0;
    if (sel_vld) begin
      pay_sel = sel ? {axi_s1_tdata_i, axi_s1_tuser_i, axi_s1_tkeep_i, axi_s1_tlast_i}
                    : {axi_s0_tdata_i, axi_s0_tuser_i, axi_s0_tkeep_i, axi_s0_tlast_i};
    end
    vld_sel = rst_n & sel_vld & (sel ? axi_s1_tvalid_i : axi_s0_tvalid_i);
  end

  assign hs              = vld_sel & up_ready;
  assign axi_s0_tready_o = rst_n & sel_vld & ~sel & up_ready;
  assign axi_s1_tready_o = rst_n & sel_vld & sel & up_ready;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    if (hs) begin
      if (pay_sel[0]) begin
        state_d       = IDLE;
        last_served_d = sel;
      end else begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

`ifdef AXIS_SWITCH_OUT_REG_EN
  logic [PayW-1:0] mem_q [2];
  logic [PayW-1:0] mem_d [2];
  logic            wr_q, wr_d, rd_q, rd_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pop;

  assign up_ready = rst_n & (cnt_q != 2'd2);
  assign m0_valid = (cnt_q != 2'd0);
  assign pay_out  = mem_q[rd_q];
  assign pop      = m0_valid & axi_m0_tready_i;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (hs) begin
      mem_d[wr_q] = pay_sel;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, hs} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign up_ready = axi_m0_tready_i;
  assign m0_valid = vld_sel;
  assign pay_out  = pay_sel;
`endif

  assign axi_m0_tvalid_o = m0_valid;
  assign {axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tkeep_o, axi_m0_tlast_o} = pay_out;

endmodule

// File: tb/tb_axi4_switch_custom.sv
// Self-checking bench for axi4_switch_custom (default zero-latency build).
module tb_axi4_switch_custom;
  localparam int TD = 512;
  localparam int TU = 81;
  localparam int TK = 16;

  typedef struct packed {
    logic [TD-1:0] d;
    logic [TU-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    sup;
  logic [TD-1:0] td [2];
  logic [TU-1:0] tu [2];
  logic [TK-1:0] tk [2];
  logic          tl [2];
  logic          tv [2];
  logic          s0_rdy, s1_rdy;
  logic [TD-1:0] m_data;
  logic [TU-1:0] m_user;
  logic [TK-1:0] m_keep;
  logic          m_last, m_valid, m_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_switch_custom dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_req_supress   (sup),
    .axi_s0_tdata_i  (td[0]),
    .axi_s0_tuser_i  (tu[0]),
    .axi_s0_tlast_i  (tl[0]),
    .axi_s0_tkeep_i  (tk[0]),
    .axi_s0_tvalid_i (tv[0]),
    .axi_s0_tready_o (s0_rdy),
    .axi_s1_tdata_i  (td[1]),
    .axi_s1_tuser_i  (tu[1]),
    .axi_s1_tlast_i  (tl[1]),
    .axi_s1_tkeep_i  (tk[1]),
    .axi_s1_tvalid_i (tv[1]),
    .axi_s1_tready_o (s1_rdy),
    .axi_m0_tdata_o  (m_data),
    .axi_m0_tuser_o  (m_user),
    .axi_m0_tlast_o  (m_last),
    .axi_m0_tkeep_o  (m_keep),
    .axi_m0_tvalid_o (m_valid),
    .axi_m0_tready_i (m_ready)
  );

  task automatic put(input int i, input logic v, input logic [31:0] d, input logic l);
    tv[i] = v;
    td[i] = TD'(d);
    tu[i] = TU'(d ^ 32'h1111_0000);
    tk[i] = '1;
    tl[i] = l;
  endtask

  task automatic idle_inputs();
    tv[0] = 1'b0;
    tv[1] = 1'b0;
    sup   = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sup = 2'b00;
    m_ready = 1'b1;
    put(0, 1'b1, 32'h1, 1'b1);
    put(1, 1'b1, 32'h2, 1'b1);
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (s0_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy0 got=%b exp=0", s0_rdy); end
    checks++; if (s1_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy1 got=%b exp=0", s1_rdy); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    @(negedge clk);
    put(0, 1'b1, 32'hA001_0001, 1'b1);
    tu[0] = TU'(32'hB001_0001);
    m_ready = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== TD'(32'hA001_0001)) begin failures++; $display("FAIL single_data got=%0h exp=a0010001", m_data); end
    checks++; if (m_user !== TU'(32'hB001_0001)) begin failures++; $display("FAIL single_user got=%0h exp=b0010001", m_user); end
    checks++; if (m_last !== 1'b1) begin failures++; $display("FAIL single_last got=%b exp=1", m_last); end
    checks++; if (m_keep !== {TK{1'b1}}) begin failures++; $display("FAIL single_keep got=%0h exp=ffff", m_keep); end
    checks++; if (s0_rdy !== 1'b1) begin failures++; $display("FAIL single_rdy0 got=%b exp=1", s0_rdy); end
    // Still IDLE afterwards: a lone s1 beat is accepted at once.
    @(negedge clk);
    tv[0] = 1'b0;
    put(1, 1'b1, 32'hA002_0001, 1'b1);
    #1;
    checks++; if (s1_rdy !== 1'b1) begin failures++; $display("FAIL single_idle_rdy1 got=%b exp=1", s1_rdy); end
    checks++; if (m_data !== TD'(32'hA002_0001)) begin failures++; $display("FAIL single_idle_data got=%0h exp=a0020001", m_data); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_no_interleave();
    logic [31:0] exp_d [4] = '{32'hA005_0001, 32'hA005_0002, 32'hA005_0003, 32'hA006_0001};
    logic        exp_r0 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c < 3) put(1, 1'b1, 32'hA005_0001 + 32'(c), (c == 2));
      else tv[1] = 1'b0;
      if (c >= 1) put(0, 1'b1, 32'hA006_0001, 1'b1);
      #1;
      checks++; if (m_data !== TD'(exp_d[c])) begin failures++; $display("FAIL nointl_data%0d got=%0h exp=%0h", c, m_data, exp_d[c]); end
      checks++; if (s0_rdy !== exp_r0[c]) begin failures++; $display("FAIL nointl_rdy0_%0d got=%b exp=%b", c, s0_rdy, exp_r0[c]); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_both_same_cycle();
    int i0 = 0;
    int i1 = 0;
    int n = 0;
    logic [31:0] got_d [4];
    logic        got_l [4];
    logic [31:0] exp_d [4] = '{32'hB0A0_0002, 32'hB0A0_0002, 32'hA0A0_0002, 32'hA0A0_0002};
    logic        exp_l [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 8 && n < 4; c++) begin
      @(negedge clk);
      put(0, (i0 < 2), 32'hA0A0_0002, (i0 == 1));
      put(1, (i1 < 2), 32'hB0A0_0002, (i1 == 1));
      #1;
      if (m_valid && m_ready) begin
        got_d[n] = m_data[31:0];
        got_l[n] = m_last;
        n++;
      end
      if (s0_rdy && tv[0]) i0++;
      if (s1_rdy && tv[1]) i1++;
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL both_count got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) begin
        failures++;
        $display("FAIL both_beat%0d got=%0h/%b exp=%0h/%b", k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    put(0, 1'b1, 32'hA008_0001, 1'b0);
    m_ready = 1'b1;
    #1;
    checks++; if (s0_rdy !== 1'b1) begin failures++; $display("FAIL bp_first_rdy got=%b exp=1", s0_rdy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      put(0, 1'b1, 32'hA008_0002, 1'b1);
      m_ready = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== TD'(32'hA008_0002) || s0_rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b/%0h/%b exp=1/a0080002/0", c, m_valid, m_data, s0_rdy);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    checks++;
    if (s0_rdy !== 1'b1 || m_last !== 1'b1 || m_data !== TD'(32'hA008_0002)) begin
      failures++;
      $display("FAIL bp_resume got=%b/%b/%0h exp=1/1/a0080002", s0_rdy, m_last, m_data);
    end
    @(negedge clk);
    tv[0] = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_nodup got=%b exp=0", m_valid); end
  endtask

  task automatic test_suppress();
    @(negedge clk);
    put(1, 1'b1, 32'hC000_0001, 1'b1);
    #1;
    checks++; if (s1_rdy !== 1'b1) begin failures++; $display("FAIL sup_pre_rdy1 got=%b exp=1", s1_rdy); end
    @(negedge clk);
    sup = 2'b01;
    put(0, 1'b1, 32'hC000_0010, 1'b1);
    put(1, 1'b1, 32'hC000_0011, 1'b0);
    #1;
    checks++;
    if (s1_rdy !== 1'b1 || s0_rdy !== 1'b0 || m_data !== TD'(32'hC000_0011)) begin
      failures++;
      $display("FAIL sup_grant1 got=%b/%b/%0h exp=1/0/c0000011", s1_rdy, s0_rdy, m_data);
    end
    @(negedge clk);
    sup = 2'b10;
    put(1, 1'b1, 32'hC000_0012, 1'b1);
    #1;
    checks++;
    if (s1_rdy !== 1'b1 || s0_rdy !== 1'b0 || m_data !== TD'(32'hC000_0012)) begin
      failures++;
      $display("FAIL sup_midpkt got=%b/%b/%0h exp=1/0/c0000012", s1_rdy, s0_rdy, m_data);
    end
    @(negedge clk);
    sup = 2'b11;
    put(1, 1'b1, 32'hC000_0013, 1'b1);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s0_rdy !== 1'b0 || s1_rdy !== 1'b0) begin
      failures++;
      $display("FAIL sup_both got=%b/%b/%b exp=0/0/0", m_valid, s0_rdy, s1_rdy);
    end
    @(negedge clk);
    sup = 2'b00;
    #1;
    checks++; if (s0_rdy !== 1'b1 || s1_rdy !== 1'b0) begin failures++; $display("FAIL sup_release got=%b/%b exp=1/0", s0_rdy, s1_rdy); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random_scoreboard();
    beat_t q [2][$];
    beat_t b;
    int    n_in [2];
    int    out_cnt = 0;
    int    owner = -1;
    int    lastsv = 1;
    logic  hs [2] = '{1'b0, 1'b0};
    int    es;
    logic  r0, r1, ev, er0, er1;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    n_in[0] = $urandom_range(5, 10);
    n_in[1] = 15 - n_in[0];
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < n_in[i]; k++) begin
        b.d = TD'({16'(i), 16'(k), $urandom()});
        b.u = TU'({$urandom(), $urandom()});
        b.l = (k == n_in[i] - 1) || ($urandom_range(0, 2) == 0);
        q[i].push_back(b);
      end
    end
    for (int c = 0; c < 400 && out_cnt < 15; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!(tv[i] && !hs[i])) begin
          tv[i] = (q[i].size() > 0) && ($urandom_range(0, 9) < 7);
          if (q[i].size() > 0) begin
            td[i] = q[i][0].d;
            tu[i] = q[i][0].u;
            tl[i] = q[i][0].l;
          end else begin
            td[i] = TD'($urandom());
            tl[i] = 1'b0;
          end
          tk[i] = TK'($urandom());
        end
      end
      sup = {1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 15)};
      m_ready = ($urandom_range(0, 9) < 7);
      #1;
      r0 = tv[0] && !sup[0];
      r1 = tv[1] && !sup[1];
      if (owner >= 0) es = owner;
      else if (r0 && r1) es = 1 - lastsv;
      else if (r0) es = 0;
      else if (r1) es = 1;
      else es = -1;
      ev  = (es >= 0) && tv[(es < 0) ? 0 : es];
      er0 = (es == 0) && m_ready;
      er1 = (es == 1) && m_ready;
      checks++;
      if (m_valid !== ev || s0_rdy !== er0 || s1_rdy !== er1) begin
        failures++;
        $display("FAIL rnd_ctrl c=%0d got=%b/%b/%b exp=%b/%b/%b", c, m_valid, s0_rdy, s1_rdy, ev, er0, er1);
      end
      hs[0] = 1'b0;
      hs[1] = 1'b0;
      if (ev) begin
        b = q[es][0];
        checks++;
        if (m_data !== b.d || m_user !== b.u || m_last !== b.l || m_keep !== tk[es]) begin
          failures++;
          $display("FAIL rnd_data c=%0d got=%0h/%b exp=%0h/%b", c, m_data[63:0], m_last, b.d[63:0], b.l);
        end
        if (m_ready) begin
          hs[es] = 1'b1;
          void'(q[es].pop_front());
          out_cnt++;
          if (b.l) begin
            owner  = -1;
            lastsv = es;
          end else begin
            owner = es;
          end
        end
      end
    end
    checks++; if (out_cnt !== 15) begin failures++; $display("FAIL rnd_count got=%0d exp=15", out_cnt); end
    @(negedge clk);
    idle_inputs();
    m_ready = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    put(0, 1'b1, 32'hD000_0001, 1'b1);
    #1;
    checks++; if (s0_rdy !== 1'b1) begin failures++; $display("FAIL rst_pre_rdy0 got=%b exp=1", s0_rdy); end
    @(negedge clk);
    put(0, 1'b1, 32'hD000_0002, 1'b0);
    @(negedge clk);
    put(0, 1'b1, 32'hD000_0003, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || s0_rdy !== 1'b0) begin failures++; $display("FAIL rst_mid got=%b/%b exp=0/0", m_valid, s0_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    put(0, 1'b1, 32'hD000_0004, 1'b1);
    put(1, 1'b1, 32'hD000_0005, 1'b1);
    #1;
    checks++;
    if (s0_rdy !== 1'b1 || s1_rdy !== 1'b0 || m_data !== TD'(32'hD000_0004)) begin
      failures++;
      $display("FAIL rst_regrant got=%b/%b/%0h exp=1/0/d0000004", s0_rdy, s1_rdy, m_data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_no_interleave();
    test_both_same_cycle();
    test_backpressure();
    test_suppress();
    test_random_scoreboard();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
